// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit.
//
// Owns the program counter, drives a combinational byte-addressed instruction
// memory and registers each returned little-endian word with its PC into a
// valid/ready output register for the decode stage. It supports stall
// back-pressure, a taken-branch redirect that also flushes the output, and a
// halt state that is entered when the halt word is fetched.
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous, active-high reset
//   enable               fetch permitted this cycle
//   branch_taken         single-cycle redirect request
//   branch_target        redirect byte address (realigned to byte_W)
//   mem_address          instruction memory address, equal to pc
//   mem_instruction_data word returned combinationally for mem_address
//   out_valid            out_instruction/out_pc hold a fetched instruction
//   out_ready            decode accepts the output when out_valid is also high
//   out_instruction      fetched instruction word
//   out_pc               byte address out_instruction was fetched from
//   halted               fetching is stopped until a redirect or reset
module instruction_fetch_unit #(
  parameter int unsigned           byte_W    = 4,
  parameter int unsigned           Addr_W    = 8,
  parameter logic [8*byte_W-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  branch_taken,
  input  logic [Addr_W-1:0]     branch_target,
  output logic [Addr_W-1:0]     mem_address,
  input  logic [8*byte_W-1:0]   mem_instruction_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*byte_W-1:0]   out_instruction,
  output logic [Addr_W-1:0]     out_pc,
  output logic                  halted
);

  // Clears the sub-word bits of a byte address; works for byte_W == 1 too.
  localparam logic [Addr_W-1:0] AlignMask = ~Addr_W'(byte_W - 1);
  localparam logic [Addr_W-1:0] PcStep    = Addr_W'(byte_W);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e                state_q, state_d;
  logic [Addr_W-1:0]     pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [8*byte_W-1:0]   instr_q, instr_d;
  logic [Addr_W-1:0]     opc_q, opc_d;

  logic slot_free;
  logic consumed;
  logic fetch_fire;
  logic is_halt_word;

  assign slot_free    = !valid_q || out_ready;
  assign consumed     = valid_q && out_ready;
  assign fetch_fire   = (state_q == StRun) && enable && slot_free && !branch_taken;
  assign is_halt_word = (mem_instruction_data == HALT_WORD);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;

    // A consumed word leaves the register empty unless refilled below.
    if (consumed) begin
      valid_d = 1'b0;
    end

    if (branch_taken) begin
      pc_d    = branch_target & AlignMask;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (fetch_fire) begin
      if (is_halt_word) begin
        // Halt word is swallowed; pc stays pointing at it.
        state_d = StHalted;
      end else begin
        instr_d = mem_instruction_data;
        opc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + PcStep;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  assign mem_address     = pc_q;
  assign out_valid       = valid_q;
  assign out_instruction = instr_q;
  assign out_pc          = opc_q;
  assign halted          = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a byte-array memory, a cycle model of the
// fetch behaviour checked every cycle, and directed scenarios with literal
// expectations.
module tb_instruction_fetch_unit;

  localparam int unsigned BW = 4;
  localparam int unsigned AW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            branch_taken;
  logic [AW-1:0]   branch_target;
  logic [AW-1:0]   mem_address;
  logic [8*BW-1:0] mem_instruction_data;
  logic            out_valid;
  logic            out_ready;
  logic [8*BW-1:0] out_instruction;
  logic [AW-1:0]   out_pc;
  logic            halted;

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .byte_W    (BW),
    .Addr_W    (AW),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .branch_taken         (branch_taken),
    .branch_target        (branch_target),
    .mem_address          (mem_address),
    .mem_instruction_data (mem_instruction_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_instruction      (out_instruction),
    .out_pc               (out_pc),
    .halted               (halted)
  );

  // Little-endian combinational memory, addresses wrap at 256.
  assign mem_instruction_data = {mem[mem_address + 8'd3], mem[mem_address + 8'd2],
                                 mem[mem_address + 8'd1], mem[mem_address]};

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: what the fetch stage must hold after each edge.
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_opc;
  logic        m_halt;
  logic        m_live = 1'b0;

  always begin
    logic        consumed;
    logic [31:0] w;
    @(posedge clk);
    if (reset) begin
      m_pc = 8'h00; m_valid = 1'b0; m_instr = 32'h0; m_opc = 8'h00; m_halt = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      consumed = m_valid && out_ready;
      if (branch_taken) begin
        m_pc    = {branch_target[7:2], 2'b00};
        m_valid = 1'b0;
        m_halt  = 1'b0;
      end else if (!m_halt && enable && (!m_valid || out_ready)) begin
        w = word_at(m_pc);
        if (w == 32'hFFFF_FFFF) begin
          m_halt = 1'b1;
          if (consumed) m_valid = 1'b0;
        end else begin
          m_instr = w;
          m_opc   = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 8'd4;
        end
      end else if (consumed) begin
        m_valid = 1'b0;
      end
    end
    #1;
    if (m_live) begin
      chk("model_mem_address", mem_address, m_pc);
      chk("model_out_valid", out_valid, m_valid);
      chk("model_out_instruction", out_instruction, m_instr);
      chk("model_out_pc", out_pc, m_opc);
      chk("model_halted", halted, m_halt);
    end
  end

  initial begin
    logic [15:0] rdy_pat;
    logic [15:0] en_pat;
    int budget;
    rdy_pat = 16'b1011_0110_1101_0011;
    en_pat  = 16'b1110_1101_1011_1111;

    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    {mem[0], mem[1], mem[2], mem[3]}     = {8'h00, 8'h10, 8'h12, 8'hE4};
    {mem[4], mem[5], mem[6], mem[7]}     = {8'h04, 8'h30, 8'h12, 8'hE4};
    {mem[8], mem[9], mem[10], mem[11]}   = {8'h01, 8'h21, 8'h83, 8'hE0};
    {mem[12], mem[13], mem[14], mem[15]} = {8'h00, 8'h00, 8'h00, 8'h18};

    cyc(2);
    chk("reset_valid", out_valid, 0);
    chk("reset_out_pc", out_pc, 0);
    chk("reset_instr", out_instruction, 0);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_halted", halted, 0);

    // Streaming, one instruction per cycle.
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    cyc(1); chk("seq0_valid", out_valid, 1);
    chk("seq0_pc", out_pc, 8'h00); chk("seq0_instr", out_instruction, 32'hE412_1000);
    cyc(1); chk("seq1_pc", out_pc, 8'h04); chk("seq1_instr", out_instruction, 32'hE412_3004);
    cyc(1); chk("seq2_pc", out_pc, 8'h08); chk("seq2_instr", out_instruction, 32'hE083_2101);
    cyc(1); chk("seq3_pc", out_pc, 8'h0C); chk("seq3_instr", out_instruction, 32'h1800_0000);

    // Back to 0x04, then stall on it.
    branch_taken = 1'b1; branch_target = 8'h04;
    cyc(1); branch_taken = 1'b0;
    chk("redir4_valid", out_valid, 0); chk("redir4_mem_address", mem_address, 8'h04);
    cyc(1); chk("stall_first_pc", out_pc, 8'h04);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 8'h04);
      chk("stall_instr", out_instruction, 32'hE412_3004);
      chk("stall_mem_address", mem_address, 8'h08);
    end
    out_ready = 1'b1;
    cyc(1); chk("release_pc", out_pc, 8'h08); chk("release_instr", out_instruction, 32'hE083_2101);

    // Misaligned redirect during a stall.
    out_ready = 1'b0;
    cyc(1); branch_taken = 1'b1; branch_target = 8'h0B;
    cyc(1); branch_taken = 1'b0; out_ready = 1'b1;
    chk("redirB_valid", out_valid, 0); chk("redirB_mem_address", mem_address, 8'h08);
    cyc(1); chk("redirB_pc", out_pc, 8'h08); chk("redirB_out_valid", out_valid, 1);

    // Address wrap.
    branch_taken = 1'b1; branch_target = 8'hFC;
    cyc(1); branch_taken = 1'b0; chk("wrap_mem_address_fc", mem_address, 8'hFC);
    cyc(1); chk("wrap_pc_fc", out_pc, 8'hFC);
    chk("wrap_instr", out_instruction, 32'hFFFE_FDFC);
    chk("wrap_mem_address_0", mem_address, 8'h00);
    cyc(1); chk("wrap_pc_0", out_pc, 8'h00);

    // Halt word at 0x10.
    {mem[16], mem[17], mem[18], mem[19]} = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    branch_taken = 1'b1; branch_target = 8'h00;
    cyc(1); branch_taken = 1'b0;
    budget = 0;
    while (!halted && budget < 20) begin
      cyc(1);
      budget++;
    end
    chk("halt_reached", halted, 1);
    chk("halt_valid", out_valid, 0);
    chk("halt_mem_address", mem_address, 8'h10);
    chk("halt_last_pc", out_pc, 8'h0C);
    cyc(3);
    chk("halt_hold", halted, 1); chk("halt_hold_addr", mem_address, 8'h10);
    branch_taken = 1'b1; branch_target = 8'h00;
    cyc(1); branch_taken = 1'b0;
    chk("unhalt_halted", halted, 0); chk("unhalt_addr", mem_address, 8'h00);
    chk("unhalt_valid", out_valid, 0);
    cyc(1); chk("unhalt_fetch_valid", out_valid, 1); chk("unhalt_fetch_pc", out_pc, 8'h00);

    // Mixed enable / ready patterns, checked by the model.
    for (int i = 0; i < 16; i++) begin
      out_ready = rdy_pat[i];
      enable    = en_pat[i];
      cyc(1);
    end

    // Restart, then reset while stalled (with a competing redirect).
    enable = 1'b1; out_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h00;
    cyc(1); branch_taken = 1'b0;
    cyc(2);
    out_ready = 1'b0;
    cyc(1); chk("prereset_valid", out_valid, 1);
    reset = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
    cyc(1); reset = 1'b0; branch_taken = 1'b0;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_pc", out_pc, 0);
    chk("midreset_instr", out_instruction, 0);
    chk("midreset_mem_address", mem_address, 0);
    chk("midreset_halted", halted, 0);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that sits directly upstream of the combinational byte-addressed instruction memory. It owns the program counter and drives the memory address. It registers the returned little-endian instruction word with its PC into a valid/ready output register for the decode stage. It supports stall back-pressure, taken-branch redirect/flush and a halt state.

Parameters:
byte_W  4  instruction width in bytes; must be a power of two; PC increment = byte_W
Addr_W  8  PC / memory address width in bits; PC arithmetic is modulo 2^Addr_W
HALT_WORD  32'hFFFF_FFFF  fetched word (width 8*byte_W) that stops fetching

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
enable  input  1  fetch permitted this cycle
branch_taken  input  1  redirect request, single-cycle pulse
branch_target  input  Addr_W  redirect byte address
mem_address  output  Addr_W  address to instruction memory; equals pc combinationally
mem_instruction_data  input  8*byte_W  word returned combinationally by memory for mem_address
out_valid  output  1  out_instruction/out_pc hold a valid fetched instruction
out_ready  input  1  decode consumes the output when out_valid && out_ready
out_instruction  output  8*byte_W  fetched instruction word
out_pc  output  Addr_W  byte address out_instruction was fetched from
halted  output  1  FSM is in HALTED

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: pc=0, out_valid=0, out_instruction=0, out_pc=0, halted=0, FSM=RUN. Reset has priority over every other input, including mid-stall and mid-redirect.
- mem_address = pc, with zero-cycle combinational path. Memory read is combinational, so the word is sampled in the same cycle.
- slot_free = !out_valid || out_ready.
- fetch_fire = FSM==RUN && enable && slot_free && !branch_taken.
- FSM states:
  - RUN: normal fetching.
  - HALTED: no fetch, pc frozen, halted=1.
- Priority per cycle: reset > branch_taken > stall > fetch.
- branch_taken=1, in any state and regardless of out_ready or enable:
  - pc <= branch_target with low log2(byte_W) bits forced to 0.
  - out_valid <= 0, which flushes the held instruction. A consumption in that same cycle still counts.
  - FSM <= RUN, halted <= 0.
  - No fetch that cycle. First fetch from the target occurs on the next cycle at the earliest.
- fetch_fire with mem_instruction_data != HALT_WORD:
  - out_instruction <= mem_instruction_data, out_pc <= pc, out_valid <= 1.
  - pc <= (pc + byte_W) mod 2^Addr_W. Example: 0xFC -> 0x00 for Addr_W=8, byte_W=4.
- fetch_fire with mem_instruction_data == HALT_WORD:
  - Word not delivered; out_valid <= 0 if consumed this cycle, else unchanged.
  - pc unchanged; FSM <= HALTED, halted <= 1 from the next cycle.
- Stall (out_valid && !out_ready): out_valid, out_instruction, out_pc and pc all hold unchanged. Outputs stay stable while valid and not accepted.
- No fetch (enable=0, or HALTED) with out_valid && out_ready: out_valid <= 0, pc holds.
- Throughput: with enable=1 and out_ready=1 held, one instruction per cycle. First out_valid appears 1 cycle after reset deasserts.
- out_instruction and out_pc are not cleared on flush; only out_valid qualifies them.
- Halt detection compares the full word only; partial matches are ignored.

Test Plan:
- Reset, then enable=1, out_ready=1; memory holds bytes 00 10 12 E4 / 04 30 12 E4 / 01 21 83 E0 / 00 00 00 18 at 0..15.
  -> Consecutive cycles show (out_pc, out_instruction) = (0x00, 0xE4121000), (0x04, 0xE4123004), (0x08, 0xE0832101), (0x0C, 0x18000000).
- Stall: out_ready=0 for 3 cycles while holding pc=0x04.
  -> Output held at (0x04, 0xE4123004); mem_address stays 0x08; releasing out_ready gives 0x08 next cycle with no skip or duplicate.
- Redirect: branch_taken=1, branch_target=0x0B during a stall.
  -> Next cycle out_valid=0, mem_address=0x08 (aligned); the following cycle out_pc=0x08.
- Wrap: redirect to 0xFC.
  -> Fetch at 0xFC, then mem_address=0x00 and next out_pc=0x00.
- Halt: place FF FF FF FF at 0x10 and run from 0.
  -> After out_pc=0x0C is consumed, halted=1, out_valid=0, mem_address stays 0x10. A redirect to 0x00 clears halted and fetching restarts.
- Reset asserted mid-stream while out_valid=1 and stalled.
  -> Next cycle out_valid=0, out_pc=0, out_instruction=0, mem_address=0, halted=0.
